// File: rtl/rom_fetch_responder.sv
// Single-word instruction buffer in front of a byte-wide backing memory.
// Misses stall fetch while four bytes are gathered over a req/ack handshake.
module rom_fetch_responder #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rom_address,
  input  logic        inv,
  output logic [31:0] rom_data,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata
);

  localparam int unsigned TAG_W  = 30;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t              state, state_n;
  logic                valid, valid_n;
  logic [TAG_W-1:0]    tag, tag_n;
  logic [TAG_W-1:0]    fill_tag, fill_tag_n;
  logic [WORD_W-1:0]   word, word_n;
  logic [1:0]          cnt, cnt_n;
  logic                mem_req_n;
  logic [WORD_W-1:0]   mem_addr_n;
  logic [TAG_W-1:0]    fetch_tag;
  logic                hit;

  // Byte offset within the word is irrelevant to a word fetch.
  logic unused_addr_bits;
  assign unused_addr_bits = ^rom_address[1:0];

  assign fetch_tag = rom_address[31:2];
  assign hit       = valid && (tag == fetch_tag);
  assign stall     = ~hit;
  assign rom_data  = hit ? word : NOP_INSTR;

  // Next-state and fill bookkeeping.
  always_comb begin
    state_n    = state;
    valid_n    = valid;
    tag_n      = tag;
    fill_tag_n = fill_tag;
    word_n     = word;
    cnt_n      = cnt;

    case (state)
      S_IDLE: begin
        if (!hit && !inv) begin
          fill_tag_n = fetch_tag;
          cnt_n      = 2'd0;
          valid_n    = 1'b0;
          state_n    = S_REQ;
        end
      end
      S_REQ: begin
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ack) begin
          word_n[{cnt, 3'b000} +: 8] = mem_rdata;
          if (fetch_tag != fill_tag) begin
            // Fetch was redirected mid-fill: drop the partial word.
            valid_n = 1'b0;
            state_n = S_IDLE;
          end else if (cnt == 2'd3) begin
            valid_n = 1'b1;
            tag_n   = fill_tag;
            state_n = S_IDLE;
          end else begin
            cnt_n   = cnt + 2'd1;
            state_n = S_REQ;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (inv) valid_n = 1'b0;

    // Request outputs are registered so they are Moore outputs of S_REQ.
    mem_req_n  = (state_n == S_REQ);
    mem_addr_n = (state_n == S_REQ) ? {fill_tag_n, cnt_n} : mem_addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      valid    <= 1'b0;
      tag      <= '0;
      fill_tag <= '0;
      word     <= '0;
      cnt      <= 2'd0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      state    <= state_n;
      valid    <= valid_n;
      tag      <= tag_n;
      fill_tag <= fill_tag_n;
      word     <= word_n;
      cnt      <= cnt_n;
      mem_req  <= mem_req_n;
      mem_addr <= mem_addr_n;
    end
  end

endmodule

// File: tb/tb_rom_fetch_responder.sv
// Directed bench for rom_fetch_responder: byte memory responder with
// programmable ack delay, a word-level buffer model and per-cycle compare.
module tb_rom_fetch_responder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_address;
  logic        inv;
  logic [31:0] rom_data;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  mem [0:511];
  logic [31:0] addr_log [$];
  int          ack_delay = 1;
  logic [31:0] ack_addr = '0;

  // Model: the word buffered for a tag, if any.
  logic        m_valid = 1'b0;
  logic [29:0] m_tag   = '0;
  logic [31:0] m_word  = '0;

  rom_fetch_responder #(.NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_address (rom_address),
    .inv         (inv),
    .rom_data    (rom_data),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [8:0] b;
    b = {a[8:2], 2'b00};
    return {mem[b + 9'd3], mem[b + 9'd2], mem[b + 9'd1], mem[b]};
  endfunction

  // Backing memory: one outstanding request, ack in the ack_delay-th wait cycle.
  initial begin : responder
    bit          pend;
    int          wcnt;
    logic [31:0] pend_addr;
    pend = 1'b0; wcnt = 0; pend_addr = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (!rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          wcnt++;
          if (wcnt >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[pend_addr[8:0]];
            ack_addr  = pend_addr;
            pend      = 1'b0;
          end
        end
        if (mem_req === 1'b1) begin
          if (pend) begin
            n_vec++; n_err++;
            $display("FAIL overlap: request at %h while %h outstanding", mem_addr, pend_addr);
          end
          pend = 1'b1; wcnt = 0; pend_addr = mem_addr;
          addr_log.push_back(mem_addr);
        end
      end
    end
  end

  // Per-cycle compare against the model, then advance the model over the next edge.
  always @(negedge clk) begin : compare
    logic h;
    h = m_valid && (m_tag == rom_address[31:2]);
    check("stall", 32'(stall), 32'(!h));
    check("rom_data", rom_data, h ? m_word : NOP);
    if (!rst) begin
      m_valid = 1'b0;
    end else begin
      if (!h) m_valid = 1'b0;
      if (mem_ack) begin
        if (rom_address[31:2] != ack_addr[31:2]) m_valid = 1'b0;
        else if (ack_addr[1:0] == 2'd3) begin
          m_valid = 1'b1;
          m_tag   = ack_addr[31:2];
          m_word  = mem_word(ack_addr);
        end
      end
      if (inv) m_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Counts cycles from the current one until stall drops.
  task automatic run_until_hit(input string nm, input int exp_k);
    int k = 0;
    @(negedge clk);
    while (stall !== 1'b0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (stall !== 1'b0) begin
      n_vec++; n_err++;
      $display("FAIL %s: timeout, stall still %b after %0d cycles", nm, stall, k);
    end else begin
      check(nm, 32'(k), 32'(exp_k));
    end
  endtask

  task automatic check_seq(input string nm, input logic [31:0] base, input int n, input int start);
    for (int i = 0; i < n; i++) begin
      if (start + i < addr_log.size()) begin
        check(nm, addr_log[start + i], base + 32'(i));
      end else begin
        n_vec++; n_err++;
        $display("FAIL %s: request %0d missing, required %h", nm, start + i, base + 32'(i));
      end
    end
  endtask

  initial begin : driver
    for (int i = 0; i < 512; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h50; mem[3] = 8'h00;
    rst = 1'b0; rom_address = '0; inv = 1'b0; ack_delay = 1;

    // Reset state.
    repeat (2) tick();
    check("rst_stall", 32'(stall), 32'd1);
    check("rst_data", rom_data, 32'h00000013);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_maddr", mem_addr, 32'd0);

    // Cold miss at 0x0, ack one cycle after each request.
    addr_log.delete();
    rst = 1'b1; rom_address = 32'h0;
    run_until_hit("t1_penalty", 9);
    check("t1_word", rom_data, 32'h00500513);
    check("t1_nreq", 32'(addr_log.size()), 32'd4);
    check_seq("t1_maddr", 32'h0, 4, 0);

    // Unaligned re-read of the buffered word hits with no request.
    tick(); addr_log.delete(); rom_address = 32'h2;
    @(negedge clk);
    check("t2_stall", 32'(stall), 32'd0);
    check("t2_word", rom_data, 32'h00500513);
    repeat (3) tick();
    check("t2_nreq", 32'(addr_log.size()), 32'd0);

    // Slow memory: ack in the third wait cycle.
    ack_delay = 3; tick(); addr_log.delete(); rom_address = 32'h104;
    run_until_hit("t3_penalty", 17);
    check("t3_word", rom_data, 32'h342D261F);
    check("t3_nreq", 32'(addr_log.size()), 32'd4);
    check_seq("t3_maddr", 32'h104, 4, 0);

    // Redirect from 0x8 to 0x20 after the second ack aborts the fill.
    ack_delay = 1; tick(); addr_log.delete(); rom_address = 32'h8;
    repeat (5) tick();
    rom_address = 32'h20;
    run_until_hit("t4_penalty", 11);
    check("t4_word", rom_data, 32'hF8F1EAE3);
    check("t4_nreq", 32'(addr_log.size()), 32'd7);
    check_seq("t4_maddr_old", 32'h8, 3, 0);
    check_seq("t4_maddr_new", 32'h20, 4, 3);
    tick(); rom_address = 32'h8;
    run_until_hit("t4_refill8", 9);
    check("t4_word8", rom_data, 32'h5049423B);

    // inv coinciding with the final ack leaves the buffer invalid.
    tick(); addr_log.delete(); rom_address = 32'h30;
    repeat (8) tick();
    inv = 1'b1;
    tick(); inv = 1'b0;
    run_until_hit("t5_refetch", 9);
    check("t5_word", rom_data, 32'h68615A53);
    check("t5_nreq", 32'(addr_log.size()), 32'd8);
    check_seq("t5_maddr_a", 32'h30, 4, 0);
    check_seq("t5_maddr_b", 32'h30, 4, 4);

    // inv on a hit: hit holds this cycle, drops after the edge.
    tick(); inv = 1'b1;
    @(negedge clk);
    check("t5_inv_hit", 32'(stall), 32'd0);
    tick(); inv = 1'b0;
    run_until_hit("t5_inv_refill", 9);

    // Asynchronous reset in the middle of a wait.
    ack_delay = 3; tick(); rom_address = 32'h40;
    repeat (3) tick();
    #1 rst = 1'b0;
    #1;
    check("t6_stall", 32'(stall), 32'd1);
    check("t6_data", rom_data, NOP);
    check("t6_req", 32'(mem_req), 32'd0);
    check("t6_maddr", mem_addr, 32'd0);
    tick(); addr_log.delete();
    tick(); rst = 1'b1;
    run_until_hit("t6_penalty", 17);
    check("t6_word", rom_data, 32'hD8D1CAC3);
    check("t6_nreq", 32'(addr_log.size()), 32'd4);
    check_seq("t6_maddr", 32'h40, 4, 0);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
